// File: rtl/approx_minmax_tracker.sv
// approx_minmax_tracker
//
// Streaming reduction stage. It takes pixels over a valid/ready handshake and
// reduces each frame of FRAME_LEN pixels to a running maximum and minimum. It
// then presents one (max, min) result per frame over a second valid/ready
// handshake.
//
// Each non-first pixel is compared against the stored max and min. The compare
// runs MSB-first, one 2-bit slice per cycle, using the approximate slice
// function. The first slice that reports greater or less decides the outcome,
// and the remaining slices are ignored.
//
// Build option:
//   APPROX_TRACKER_EXACT_CMP_EN - when defined, the approximate slice function
//   is replaced by an exact 2-bit magnitude compare. The tracker then reports
//   the true max/min. Timing and handshake are unchanged.
//
// Parameters:
//   PIX_W     pixel width, even and >= 2
//   FRAME_LEN pixels per frame, >= 1
//   CNT_W     pixel counter width, 2**CNT_W > FRAME_LEN
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   in_valid   upstream offers in_pix
//   in_ready   block can accept a pixel (IDLE only)
//   in_pix     pixel value, held by upstream until accepted
//   out_valid  frame result available (OUT state)
//   out_ready  downstream consumes the result
//   out_max    frame maximum (approximate unless exact build)
//   out_min    frame minimum (approximate unless exact build)
//   busy       high in every state except IDLE

module approx_minmax_tracker #(
    parameter int PIX_W     = 8,
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_max,
    output logic [PIX_W-1:0] out_min,
    output logic             busy
);

    localparam int NSLICE = PIX_W / 2;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(NSLICE - 1);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMP,
        S_UPDATE,
        S_OUT
    } state_t;

    state_t state, state_next;

    logic [PIX_W-1:0] px;
    logic [PIX_W-1:0] max_q;
    logic [PIX_W-1:0] min_q;
    logic [PIX_W-1:0] out_max_q;
    logic [PIX_W-1:0] out_min_q;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] idx;

    // Sticky compare flags: once a slice decides, later slices are ignored.
    logic max_dec, max_gt;
    logic min_dec, min_lt;

    // Returns {H, L} for one slice. X is the pixel slice and Y the stored
    // slice. H and L are never both set. Neither set means the slice is equal.
    function automatic logic [1:0] slice_cmp(input logic [1:0] x, input logic [1:0] y);
        logic h;
        logic l;
`ifdef APPROX_TRACKER_EXACT_CMP_EN
        h = (x > y);
        l = (x < y);
`else
        h = (x[0] & ~y[1]) | (x[1] & ~y[1]) | (x[1] & ~y[0]);
        l = ~x[1] & y[1];
`endif
        return {h, l};
    endfunction

    logic [1:0]       px_sl, max_sl, min_sl;
    logic [1:0]       max_hl, min_hl;
    logic [PIX_W-1:0] max_next, min_next;
    logic [CNT_W-1:0] count_inc;
    logic             frame_done;

    // Slice selection for the current index and the values UPDATE would
    // commit. frame_done is only meaningful in UPDATE.
    always_comb begin
        px_sl      = px[{idx, 1'b0} +: 2];
        max_sl     = max_q[{idx, 1'b0} +: 2];
        min_sl     = min_q[{idx, 1'b0} +: 2];
        max_hl     = slice_cmp(px_sl, max_sl);
        min_hl     = slice_cmp(px_sl, min_sl);
        max_next   = max_gt ? px : max_q;
        min_next   = min_lt ? px : min_q;
        count_inc  = count + CNT_W'(1);
        frame_done = (count_inc == CNT_FRAME);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = (count == '0) ? S_LOAD : S_CMP;
                end
            end
            S_LOAD: begin
                state_next = (FRAME_LEN == 1) ? S_OUT : S_IDLE;
            end
            S_CMP: begin
                if (idx == '0) begin
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                state_next = frame_done ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath. The output registers are loaded only when a frame completes.
    // They therefore stay stable through OUT and hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            px        <= '0;
            max_q     <= '0;
            min_q     <= '0;
            out_max_q <= '0;
            out_min_q <= '0;
            count     <= '0;
            idx       <= '0;
            max_dec   <= 1'b0;
            max_gt    <= 1'b0;
            min_dec   <= 1'b0;
            min_lt    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        px  <= in_pix;
                        idx <= IDX_TOP;
                    end
                end
                S_LOAD: begin
                    max_q <= px;
                    min_q <= px;
                    count <= CNT_W'(1);
                    if (FRAME_LEN == 1) begin
                        out_max_q <= px;
                        out_min_q <= px;
                    end
                end
                S_CMP: begin
                    if (!max_dec && (max_hl != 2'b00)) begin
                        max_dec <= 1'b1;
                        max_gt  <= max_hl[1];
                    end
                    if (!min_dec && (min_hl != 2'b00)) begin
                        min_dec <= 1'b1;
                        min_lt  <= min_hl[0];
                    end
                    if (idx != '0) begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                S_UPDATE: begin
                    max_q   <= max_next;
                    min_q   <= min_next;
                    count   <= count_inc;
                    max_dec <= 1'b0;
                    max_gt  <= 1'b0;
                    min_dec <= 1'b0;
                    min_lt  <= 1'b0;
                    if (frame_done) begin
                        out_max_q <= max_next;
                        out_min_q <= min_next;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        count <= '0;
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

    assign out_max = out_max_q;
    assign out_min = out_min_q;

endmodule

// File: tb/tb_approx_minmax_tracker.sv
// tb_approx_minmax_tracker
//
// Self-checking bench for approx_minmax_tracker with PIX_W=8. It uses two
// instances:
//   dut  FRAME_LEN=4, which covers the main frame, latency, backpressure and
//        mid-frame reset scenarios
//   dut1 FRAME_LEN=1, which covers the LOAD-to-OUT path
//
// Expected results come from a slice-level truth table and a per-frame
// max/min reduction. The table follows the exact compare when
// APPROX_TRACKER_EXACT_CMP_EN is defined.

module tb_approx_minmax_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] in_pix, out_max, out_min;

    logic       in_valid_1, in_ready_1, out_valid_1, out_ready_1, busy_1;
    logic [7:0] in_pix_1, out_max_1, out_min_1;

    int total = 0;
    int bad   = 0;

    logic [7:0] frame_pix [4];

    always #5 clk = ~clk;

    approx_minmax_tracker #(.PIX_W(8), .FRAME_LEN(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_min(out_min), .busy(busy)
    );

    approx_minmax_tracker #(.PIX_W(8), .FRAME_LEN(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_1), .in_ready(in_ready_1), .in_pix(in_pix_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1),
        .out_max(out_max_1), .out_min(out_min_1), .busy(busy_1)
    );

    // Slice relation of pixel slice x against stored slice y:
    // +1 greater, -1 less, 0 equal.
    function automatic int slice_rel(input logic [1:0] x, input logic [1:0] y);
`ifdef APPROX_TRACKER_EXACT_CMP_EN
        if (x > y) return 1;
        if (x < y) return -1;
        return 0;
`else
        case ({x, y})
            4'b0000, 4'b0001:          return 0;
            4'b0010, 4'b0011:          return -1;
            4'b0100, 4'b0101:          return 1;
            4'b0110, 4'b0111:          return -1;
            4'b1000, 4'b1001, 4'b1010: return 1;
            4'b1011:                   return 0;
            4'b1100, 4'b1101, 4'b1110: return 1;
            default:                   return 0;
        endcase
`endif
    endfunction

    function automatic int word_rel(input logic [7:0] x, input logic [7:0] y);
        int r;
        for (int s = 3; s >= 0; s--) begin
            r = slice_rel(x[2*s +: 2], y[2*s +: 2]);
            if (r != 0) return r;
        end
        return 0;
    endfunction

    task automatic model_frame(output logic [7:0] emax, output logic [7:0] emin);
        emax = frame_pix[0];
        emin = frame_pix[0];
        for (int i = 1; i < 4; i++) begin
            if (word_rel(frame_pix[i], emax) > 0) emax = frame_pix[i];
            if (word_rel(frame_pix[i], emin) < 0) emin = frame_pix[i];
        end
    endtask

    // Offer one pixel to dut as soon as in_ready is seen. w=-1 on timeout.
    task automatic send_pix(input logic [7:0] p, output int w);
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) begin
            w = -1;
        end else begin
            in_valid = 1'b1;
            in_pix   = p;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Count negedges until the selected dut flag is high (0: in_ready, 1: out_valid).
    task automatic cycles_until(input int which, output int n);
        n = 0;
        while (((which == 0) ? in_ready : out_valid) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_frame(input string tag);
        int w, n, exp_n;
        logic [7:0] emax, emin;
        model_frame(emax, emin);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_pix(frame_pix[i], w);
            total++;
            if (w < 0) begin
                bad++;
                $display("[TB] FAIL %s accept[%0d]: in_ready stayed low, want 1", tag, i);
            end
            if (i < 3) begin
                cycles_until(0, n);
                exp_n = (i == 0) ? 1 : 5;
                total++;
                if (n !== exp_n) begin
                    bad++;
                    $display("[TB] FAIL %s ready_latency[%0d]: got %0d want %0d", tag, i, n, exp_n);
                end
            end else begin
                cycles_until(1, n);
                total++;
                if (n !== 5) begin
                    bad++;
                    $display("[TB] FAIL %s out_latency: got %0d want 5", tag, n);
                end
            end
        end
        total++;
        if (out_max !== emax) begin
            bad++;
            $display("[TB] FAIL %s out_max: got %h want %h", tag, out_max, emax);
        end
        total++;
        if (out_min !== emin) begin
            bad++;
            $display("[TB] FAIL %s out_min: got %h want %h", tag, out_min, emin);
        end
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL %s after_out {out_valid,in_ready}: got %b want 01", tag, {out_valid, in_ready});
        end
    endtask

    task automatic test_reset;
        logic [18:0] got;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            got = {in_ready, out_valid, busy, out_max, out_min};
            total++;
            if (got !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin
                bad++;
                $display("[TB] FAIL reset_state: got %h want %h", got, {1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
            end
            got = {in_ready_1, out_valid_1, busy_1, out_max_1, out_min_1};
            total++;
            if (got !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin
                bad++;
                $display("[TB] FAIL reset_state_1: got %h want %h", got, {1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
            end
        end
    endtask

    task automatic test_directed;
        frame_pix[0] = 8'h20;
        frame_pix[1] = 8'h10;
        frame_pix[2] = 8'h80;
        frame_pix[3] = 8'h40;
        run_frame("directed");
    endtask

    task automatic test_approx;
        frame_pix[0] = 8'h5F;
        frame_pix[1] = 8'h50;
        frame_pix[2] = 8'h50;
        frame_pix[3] = 8'h50;
        run_frame("approx");
        frame_pix[0] = 8'h00;
        frame_pix[1] = 8'hFF;
        frame_pix[2] = 8'hFF;
        frame_pix[3] = 8'h00;
        run_frame("extremes");
    endtask

    task automatic test_random;
        int sel;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 4; i++) begin
                sel = $urandom_range(0, 7);
                if (sel == 0)      frame_pix[i] = 8'h00;
                else if (sel == 1) frame_pix[i] = 8'hFF;
                else               frame_pix[i] = 8'($urandom_range(0, 255));
            end
            run_frame("random");
        end
    endtask

    task automatic test_backpressure;
        int w, n;
        logic [7:0] emax, emin;
        logic [17:0] got;
        for (int i = 0; i < 4; i++) frame_pix[i] = 8'($urandom_range(0, 255));
        model_frame(emax, emin);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_pix(frame_pix[i], w);
        cycles_until(1, n);
        total++;
        if (n > 5) begin
            bad++;
            $display("[TB] FAIL bp_out_latency: got %0d want <=5", n);
        end
        in_valid = 1'b1;
        in_pix   = 8'hEE;
        for (int k = 0; k < 5; k++) begin
            got = {out_valid, in_ready, out_max, out_min};
            total++;
            if (got !== {1'b1, 1'b0, emax, emin}) begin
                bad++;
                $display("[TB] FAIL bp_hold[%0d]: got %h want %h", k, got, {1'b1, 1'b0, emax, emin});
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL bp_release {out_valid,in_ready}: got %b want 01", {out_valid, in_ready});
        end
        for (int i = 0; i < 4; i++) frame_pix[i] = 8'($urandom_range(0, 255));
        run_frame("bp_next");
    endtask

    task automatic test_reset_midframe;
        int w, n;
        bit seen;
        out_ready = 1'b1;
        send_pix(8'h11, w);
        cycles_until(0, n);
        send_pix(8'h22, w);
        cycles_until(0, n);
        send_pix(8'h33, w);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, in_ready, out_valid} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL midreset_state {busy,in_ready,out_valid}: got %b want 010", {busy, in_ready, out_valid});
        end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen) begin
            bad++;
            $display("[TB] FAIL midreset_no_out: got out_valid=1 want 0");
        end
        frame_pix[0] = 8'h01;
        frame_pix[1] = 8'h02;
        frame_pix[2] = 8'h03;
        frame_pix[3] = 8'h04;
        run_frame("midreset_next");
    endtask

    task automatic test_frame_len1;
        logic [7:0] p;
        int n;
        out_ready_1 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            p = (t == 0) ? 8'hAA : (t == 1) ? 8'h00 : (t == 2) ? 8'hFF : 8'($urandom_range(0, 255));
            n = 0;
            while (in_ready_1 !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            in_valid_1 = 1'b1;
            in_pix_1   = p;
            @(negedge clk);
            in_valid_1 = 1'b0;
            n = 0;
            while (out_valid_1 !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (n !== 1) begin
                bad++;
                $display("[TB] FAIL len1_latency: got %0d want 1", n);
            end
            total++;
            if ({out_max_1, out_min_1} !== {p, p}) begin
                bad++;
                $display("[TB] FAIL len1_result: got %h want %h", {out_max_1, out_min_1}, {p, p});
            end
            @(negedge clk);
            total++;
            if (out_valid_1 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL len1_drop: got out_valid=%b want 0", out_valid_1);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_pix      = 8'h00;
        out_ready   = 1'b0;
        in_valid_1  = 1'b0;
        in_pix_1    = 8'h00;
        out_ready_1 = 1'b0;
        @(negedge clk);
        test_reset;
        test_directed;
        test_approx;
        test_random;
        test_backpressure;
        test_reset_midframe;
        test_frame_len1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
